// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, keeps up to DEPTH words in
// flight or buffered, and presents them in PC order to IF under valid/ready.
module fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_data
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAXO_W  = CW'(MAX_OUTSTANDING);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   head_data_q, head_data_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic          head_load;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_base;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign redirect_base  = {redirect_pc[31:2], 2'b00};

    // Buffered plus in-flight words never exceed DEPTH, so a response push can
    // never overflow the FIFO.
    assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_valid = !reset && !redirect_valid &&
                            (credit_used < DEPTH_W) && (outst_q < MAXO_W);
    assign imem_req_addr  = fetch_pc_q;
    assign instr_valid    = !reset && !redirect_valid && (count_q != '0);
    assign instr_pc       = head_pc_q;
    assign instr_data     = head_data_q;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outst_q != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            outst_d    = outst_q - CW'(resp_fire);
            discard_d  = outst_q - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                end
            end
            pop = instr_valid && instr_ready;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Head registers mirror the entry at rd_ptr; forward the incoming word when
    // it becomes the head in the same cycle it is written.
    always_comb begin
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        head_load   = !redirect_valid && (push || pop) && (count_d != '0);
        if (head_load) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_pc_d   = resp_pc_q;
                head_data_d = imem_resp_data;
            end else begin
                head_pc_d   = pc_mem[rd_ptr_d];
                head_data_d = data_mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= resp_pc_q;
            data_mem[wr_ptr_q] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            count_q     <= '0;
            outst_q     <= '0;
            discard_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            head_pc_q   <= '0;
            head_data_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand vectors, corner sequences and randomized traffic
// checked against a queue-based model of requests, tags and buffered words.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_pc;
    logic [31:0] instr_data;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_pc(instr_pc), .instr_data(instr_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t       infl_q[$];
    ent_t        fifo_q[$];
    mreq_t       mem_q[$];
    logic [31:0] m_fetch;

    bit          k_redir, k_ready, k_ir, k_stray;
    logic [31:0] k_rpc;
    int          k_lat;

    logic        last_rv, last_iv;
    logic [31:0] last_addr, last_pc;

    typedef struct {
        logic rdy; logic rv_in; logic [31:0] rdata; logic ir;
        logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_pc;
    } vec_t;
    vec_t tab[11];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic vec_t mkv(input logic rdy, input logic rv_in, input logic [31:0] rdata,
                                 input logic ir, input logic e_rv, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.rv_in = rv_in; v.rdata = rdata; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input bit check_outputs);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
        @(posedge clk); #1;
        if (check_outputs) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_req_addr", imem_req_addr, RPC);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_instr_data", instr_data, 32'h0);
        end
        @(negedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        fifo_q.delete(); infl_q.delete(); mem_q.delete();
        m_fetch = RPC;
        $display("reset applied (output check %0d)", check_outputs);
    endtask

    task automatic apply_vec(input int i);
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = tab[i].rdy; imem_resp_valid = tab[i].rv_in;
        imem_resp_data = tab[i].rdata; instr_ready = tab[i].ir;
        #1;
        chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tab[i].e_rv));
        chk($sformatf("v%0d_req_addr", i), imem_req_addr, tab[i].e_addr);
        chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tab[i].e_iv));
        if (tab[i].e_iv) begin
            chk($sformatf("v%0d_instr_pc", i), instr_pc, tab[i].e_pc);
            chk($sformatf("v%0d_instr_data", i), instr_data, memf(tab[i].e_pc));
        end
        $display("vec %0d: req_valid=%0b addr=%h instr_valid=%0b pc=%h",
                 i, imem_req_valid, imem_req_addr, instr_valid, instr_pc);
        @(posedge clk); @(negedge clk);
        cyc++;
    endtask

    // One cycle against the model; memory side follows what the DUT actually issued.
    task automatic step();
        bit          resp, mem_resp, rv_e, iv_e, act_fire;
        logic [31:0] act_addr;
        infl_t       e;
        ent_t        n;
        mem_resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        resp     = mem_resp || k_stray;
        redirect_valid  = k_redir; redirect_pc = k_rpc;
        imem_req_ready  = k_ready; instr_ready = k_ir;
        imem_resp_valid = resp;
        imem_resp_data  = mem_resp ? memf(mem_q[0].addr) : (32'hBAD0_0000 ^ 32'(cyc));
        #1;
        rv_e = !k_redir && (fifo_q.size() + infl_q.size() < DEPTH) && (infl_q.size() < MAXO);
        iv_e = !k_redir && (fifo_q.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(rv_e));
        chk("req_addr", imem_req_addr, m_fetch);
        chk("instr_valid", 32'(instr_valid), 32'(iv_e));
        if (iv_e) begin
            chk("instr_pc", instr_pc, fifo_q[0].pc);
            chk("instr_data", instr_data, fifo_q[0].data);
        end
        last_rv = imem_req_valid; last_addr = imem_req_addr;
        last_iv = instr_valid;    last_pc   = instr_pc;
        act_fire = imem_req_valid && k_ready;
        act_addr = imem_req_addr;
        if (instr_valid && instr_ready)
            $display("cyc %0d pop pc=%h data=%h", cyc, instr_pc, instr_data);
        @(posedge clk);
        if (mem_resp) void'(mem_q.pop_front());
        if (act_fire) mem_q.push_back('{addr: act_addr, due: cyc + k_lat});
        if (iv_e && k_ir && !k_redir) void'(fifo_q.pop_front());
        if (resp && infl_q.size() > 0) begin
            e = infl_q.pop_front();
            if (!k_redir && !e.stale) begin
                n.pc = e.pc; n.data = memf(e.pc);
                fifo_q.push_back(n);
            end
        end
        if (k_redir) begin
            fifo_q.delete();
            foreach (infl_q[j]) infl_q[j].stale = 1'b1;
            m_fetch = {k_rpc[31:2], 2'b00};
        end else if (rv_e && k_ready) begin
            infl_q.push_back('{pc: m_fetch, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_first(input logic [31:0] exp_pc, input string name);
        bit found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            step();
            if (last_iv) begin
                found = 1'b1;
                chk({name, "_first_pc"}, last_pc, exp_pc);
            end
        end
        chk({name, "_delivered"}, 32'(found), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
        k_redir = 1'b0; k_ready = 1'b1; k_ir = 1'b1; k_stray = 1'b0; k_rpc = '0; k_lat = 1;

        // Stall from reset: fill to 4 (a stray response first), then drain while streaming.
        tab[0]  = mkv(1'b1, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b1, 32'h00, 1'b0, 32'h00);
        tab[1]  = mkv(1'b1, 1'b1, memf(32'h00), 1'b0, 1'b1, 32'h04, 1'b0, 32'h00);
        tab[2]  = mkv(1'b1, 1'b1, memf(32'h04), 1'b0, 1'b1, 32'h08, 1'b1, 32'h00);
        tab[3]  = mkv(1'b1, 1'b1, memf(32'h08), 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00);
        tab[4]  = mkv(1'b1, 1'b1, memf(32'h0C), 1'b0, 1'b0, 32'h10, 1'b1, 32'h00);
        tab[5]  = mkv(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10, 1'b1, 32'h00);
        tab[6]  = mkv(1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10, 1'b1, 32'h00);
        tab[7]  = mkv(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10, 1'b1, 32'h04);
        tab[8]  = mkv(1'b1, 1'b1, memf(32'h10), 1'b1, 1'b1, 32'h14, 1'b1, 32'h08);
        tab[9]  = mkv(1'b1, 1'b1, memf(32'h14), 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C);
        tab[10] = mkv(1'b1, 1'b1, memf(32'h18), 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);

        @(negedge clk);
        do_reset(1'b1);
        for (int i = 0; i < 11; i++) apply_vec(i);

        // Three requests in flight at latency 4, then redirect to 0x100.
        do_reset(1'b0);
        k_ready = 1'b1; k_ir = 1'b1; k_lat = 4;
        repeat (3) step();
        k_redir = 1'b1; k_rpc = 32'h100; step();
        chk("h1_no_req_on_redirect", 32'(last_rv), 32'h0);
        k_redir = 1'b0; k_lat = 1;
        wait_first(32'h100, "h1");

        // Stalled request at 0x40 withdrawn by redirect to 0x203.
        do_reset(1'b0);
        k_ready = 1'b0; k_redir = 1'b1; k_rpc = 32'h40; step();
        k_redir = 1'b0; step();
        chk("h2_stalled_valid", 32'(last_rv), 32'h1);
        chk("h2_stalled_addr", last_addr, 32'h40);
        k_redir = 1'b1; k_rpc = 32'h203; step();
        chk("h2_withdrawn", 32'(last_rv), 32'h0);
        k_redir = 1'b0; k_ready = 1'b1; step();
        chk("h2_new_valid", 32'(last_rv), 32'h1);
        chk("h2_new_addr", last_addr, 32'h200);

        // Redirect with a response landing and IF ready at count 2.
        do_reset(1'b0);
        k_lat = 1; k_ir = 1'b0; k_ready = 1'b1;
        repeat (3) step();
        k_ready = 1'b0; k_ir = 1'b1; k_redir = 1'b1; k_rpc = 32'h300; step();
        chk("h3_no_pop_on_redirect", 32'(last_iv), 32'h0);
        k_redir = 1'b0; k_ready = 1'b1; step();
        chk("h3_empty_after", 32'(last_iv), 32'h0);
        chk("h3_addr_after", last_addr, 32'h300);
        wait_first(32'h300, "h3");

        // Mid-stream reset with words buffered and in flight.
        do_reset(1'b0);
        k_lat = 3; k_ir = 1'b0; k_ready = 1'b1;
        repeat (5) step();
        do_reset(1'b1);
        k_ready = 1'b1; k_ir = 1'b1; k_lat = 1; step();
        chk("h4_first_valid", 32'(last_rv), 32'h1);
        chk("h4_first_addr", last_addr, RPC);

        // Randomized traffic, with stall-heavy stretches to reach the credit limit.
        for (int n = 0; n < 2500; n++) begin
            k_redir = ($urandom_range(0, 15) == 0);
            k_rpc   = $urandom();
            k_ready = ($urandom_range(0, 3) != 0);
            k_ir    = (((n / 200) % 3) == 0) ? ($urandom_range(0, 5) == 0)
                                             : ($urandom_range(0, 2) != 0);
            k_lat   = int'($urandom_range(1, 3));
            k_stray = (infl_q.size() == 0) && (mem_q.size() == 0) && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) do_reset(1'b0);
            step();
        end
        k_stray = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
